// File: rtl/mesh_host_ctrl.sv
// Host initiator for the subdivision core: loads a mesh into OBJ RAM, kicks the core,
// then streams the result mesh out of RES RAM with a valid/ready handshake.
module mesh_host_ctrl #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  obj_en,
    output logic [ADDR_WIDTH-1:0] obj_a,
    output logic [3:0]            obj_we,
    output logic [31:0]           obj_di,
    output logic                  res_en,
    output logic [ADDR_WIDTH-1:0] res_a,
    input  logic [31:0]           res_do,
    output logic                  mem_own,
    output logic                  ss_start,
    input  logic                  ss_busy,
    input  logic [31:0]           ss_word_count,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_KICK, S_RUN, S_RD_REQ, S_RD_CAP, S_RD_HOLD, S_DONE, S_ERR
    } state_t;

    localparam logic [34:0]           BANK_WORDS = 35'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE    = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE    = 1;

    state_t                state_reg, state_next;
    logic                  armed_reg;
    logic [ADDR_WIDTH-1:0] load_cnt_reg, load_cnt_next;
    logic [31:0]           v_reg, v_next;
    logic [ADDR_WIDTH:0]   t_reg, t_next;
    logic [ADDR_WIDTH:0]   w_reg, w_next;
    logic [ADDR_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;
    logic [31:0]           out_data_reg, out_data_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  out_last_reg, out_last_next;
    logic                  accept;
    logic [34:0]           t_calc;

    assign accept = in_valid & in_ready;
    assign t_calc = 35'd3 * ({3'b000, v_reg} + {3'b000, in_data}) + 35'd2;

    assign obj_en = accept;
    assign obj_a  = accept ? load_cnt_reg : '0;
    assign res_a  = res_en ? rd_cnt_reg : '0;
    assign err    = (state_reg == S_ERR);

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

    // Byte lanes are written together; gating keeps the bus quiet when idle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign obj_we[gi]            = accept;
            assign obj_di[8*gi +: 8]     = accept ? in_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        load_cnt_next  = load_cnt_reg;
        v_next         = v_reg;
        t_next         = t_reg;
        w_next         = w_reg;
        rd_cnt_next    = rd_cnt_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        in_ready       = 1'b0;
        mem_own        = 1'b0;
        ss_start       = 1'b0;
        res_en         = 1'b0;
        busy           = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                // armed_reg holds everything at zero for the first cycle out of reset
                in_ready = armed_reg;
                mem_own  = armed_reg;
                if (accept) begin
                    v_next        = in_data;
                    load_cnt_next = CNT_ONE;
                    state_next    = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                mem_own  = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    load_cnt_next = load_cnt_reg + CNT_ONE;
                    if (load_cnt_reg == CNT_ONE) begin
                        if (t_calc > BANK_WORDS) begin
                            state_next = S_ERR;
                        end else begin
                            t_next = t_calc[ADDR_WIDTH:0];
                            if (t_calc == 35'd2) begin
                                load_cnt_next = '0;
                                state_next    = S_KICK;
                            end
                        end
                    end else if ({1'b0, load_cnt_reg} == (t_reg - LEN_ONE)) begin
                        load_cnt_next = '0;
                        state_next    = S_KICK;
                    end
                end
            end
            S_KICK: begin
                busy     = 1'b1;
                ss_start = 1'b1;
                if (ss_busy) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (!ss_busy) begin
                    w_next = ss_word_count[ADDR_WIDTH:0];
                    if ((ss_word_count == 32'd0) || ({3'b000, ss_word_count} > BANK_WORDS)) begin
                        state_next = S_ERR;
                    end else begin
                        rd_cnt_next = '0;
                        state_next  = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                busy       = 1'b1;
                mem_own    = 1'b1;
                res_en     = 1'b1;
                state_next = S_RD_CAP;
            end
            S_RD_CAP: begin
                busy           = 1'b1;
                mem_own        = 1'b1;
                out_data_next  = res_do;
                out_valid_next = 1'b1;
                out_last_next  = ({1'b0, rd_cnt_reg} == (w_reg - LEN_ONE));
                state_next     = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                busy    = 1'b1;
                mem_own = 1'b1;
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    rd_cnt_next    = rd_cnt_reg + CNT_ONE;
                    state_next     = out_last_reg ? S_DONE : S_RD_REQ;
                end
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_reg     <= 1'b0;
            load_cnt_reg  <= '0;
            v_reg         <= '0;
            t_reg         <= '0;
            w_reg         <= '0;
            rd_cnt_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            armed_reg     <= 1'b1;
            load_cnt_reg  <= load_cnt_next;
            v_reg         <= v_next;
            t_reg         <= t_next;
            w_reg         <= w_next;
            rd_cnt_reg    <= rd_cnt_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
        end
    end

endmodule

// File: tb/tb_mesh_host_ctrl.sv
// Scoreboard bench for mesh_host_ctrl: drivers push expected RAM writes and output
// words into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_mesh_host_ctrl;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_last;
    logic          out_ready;
    logic          obj_en;
    logic [AW-1:0] obj_a;
    logic [3:0]    obj_we;
    logic [31:0]   obj_di;
    logic          res_en;
    logic [AW-1:0] res_a;
    logic [31:0]   res_do;
    logic          mem_own;
    logic          ss_start;
    logic          ss_busy;
    logic [31:0]   ss_word_count;
    logic          busy;
    logic          err;

    mesh_host_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .obj_en(obj_en), .obj_a(obj_a), .obj_we(obj_we), .obj_di(obj_di),
        .res_en(res_en), .res_a(res_a), .res_do(res_do),
        .mem_own(mem_own), .ss_start(ss_start), .ss_busy(ss_busy),
        .ss_word_count(ss_word_count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] res_word(input logic [AW-1:0] a);
        return 32'h5A00_0000 + ({21'd0, a} * 32'd40503);
    endfunction

    // RES RAM model: one-cycle registered read
    always @(posedge clk) begin
        if (res_en) res_do <= res_word(res_a);
    end

    int checks = 0;
    int errors = 0;
    logic [42:0] obj_q[$];
    logic [32:0] out_q[$];
    int rd_exp = 0;
    int start_cycles = 0;
    int out_hs = 0;
    int sink_mode = 0;
    int core_delay = 1;
    int core_run = 10;
    logic [31:0] core_wc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outs();
        check("rst_data", {out_data, obj_di}, 64'd0);
        check("rst_ctrl", {in_ready, out_valid, out_last, obj_en, obj_a, obj_we, res_en,
                           res_a, mem_own, ss_start, busy, err}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outs();
        $display("reset: outputs checked");
        out_q.delete();
        obj_q.delete();
        rd_exp = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input int addr, input logic [31:0] d, input int gap);
        int t;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        obj_q.push_back({addr[AW-1:0], d});
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_accept_timeout actual=0 required=1 addr=%0d", addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_job(input int v, input int f, input logic [31:0] wc, input int w_exp,
                            input int delay, input int run, input int gap);
        int total;
        logic [31:0] d;
        core_delay = delay; core_run = run; core_wc = wc;
        rd_exp = 0; start_cycles = 0; out_hs = 0;
        for (int i = 0; i < w_exp; i++) out_q.push_back({(i == w_exp - 1), res_word(i[AW-1:0])});
        total = 3 * (v + f) + 2;
        for (int i = 0; i < total; i++) begin
            d = (i == 0) ? v : (i == 1) ? f : 32'h100 + i - 2;
            send_word(i, d, (gap > 0 && i % 3 == 2) ? gap : 0);
        end
        in_valid = 1'b0;
        $display("job: V=%0d F=%0d words=%0d wc=%0d streamed", v, f, total, wc);
    endtask

    task automatic finish_job(input int delay, input int w);
        int n;
        @(negedge clk);
        check("kick_in_ready", in_ready, 0);
        check("kick_busy", busy, 1);
        n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        check("job_done_timeout", busy, 0);
        check("done_flags", {in_ready, mem_own, err}, 3'b110);
        check("start_cycles", start_cycles, delay);
        check("res_reads", rd_exp, w);
        check("out_left", out_q.size(), 0);
        check("obj_left", obj_q.size(), 0);
        $display("job: complete outputs=%0d start_cycles=%0d", out_hs, start_cycles);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic stall_prev;
        logic [31:0] prev_data;
        logic prev_last;
        rst = 1'b1; in_valid = 1'b0; in_data = 0; out_ready = 1'b0;
        ss_busy = 1'b0; ss_word_count = 0;
        stall_prev = 1'b0; prev_data = 0; prev_last = 1'b0;

        fork
            begin : monitor
                logic [42:0] eo;
                logic [32:0] ew;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        stall_prev = 1'b0;
                    end else begin
                        if (obj_en) begin
                            check("obj_own", mem_own, 1);
                            if (obj_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL obj_unexpected actual=%0h:%0h required=none", obj_a, obj_di);
                            end else begin
                                eo = obj_q.pop_front();
                                check("obj_write", {obj_we, obj_a, obj_di}, {4'hF, eo});
                            end
                        end
                        if (res_en) begin
                            check("res_own", mem_own, 1);
                            check("res_addr", res_a, rd_exp[AW-1:0]);
                            rd_exp++;
                        end
                        if (ss_start) begin
                            check("start_own", mem_own, 0);
                            start_cycles++;
                        end
                        if (stall_prev)
                            check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
                        if (out_valid && out_ready) begin
                            if (out_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL out_unexpected actual=%0h required=none", out_data);
                            end else begin
                                ew = out_q.pop_front();
                                check("out_word", {out_last, out_data}, ew);
                            end
                            out_hs++;
                        end
                        stall_prev = out_valid && !out_ready;
                        prev_data  = out_data;
                        prev_last  = out_last;
                    end
                end
            end
            begin : core_model
                forever begin
                    @(negedge clk);
                    if (ss_start) begin
                        for (int k = 1; k < core_delay; k++) @(negedge clk);
                        ss_busy = 1'b1;
                        ss_word_count = 0;
                        repeat (core_run) @(negedge clk);
                        ss_word_count = core_wc;
                        ss_busy = 1'b0;
                    end
                end
            end
            begin : sink
                logic [3:0] pat;
                int cyc;
                pat = 4'b1001;
                cyc = 0;
                forever begin
                    @(posedge clk); #1;
                    out_ready = (sink_mode == 0) ? 1'b1 : pat[cyc % 4];
                    cyc++;
                end
            end
            begin : watchdog
                #500000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // nominal: V=4 F=2, 74 result words
        sink_mode = 0;
        send_job(4, 2, 74, 74, 1, 50, 0);
        finish_job(1, 74);

        // backpressure and input gaps, starting from DONE
        sink_mode = 1;
        send_job(4, 2, 74, 74, 1, 50, 1);
        finish_job(1, 74);
        sink_mode = 0;

        // start handshake: core answers after 5 cycles of ss_start
        send_job(1, 1, 6, 6, 5, 10, 0);
        finish_job(5, 6);

        // degenerate empty mesh
        send_job(0, 0, 3, 3, 1, 5, 0);
        finish_job(1, 3);

        // zero result length must error without reading RES RAM
        send_job(1, 1, 0, 0, 1, 5, 0);
        n = 0;
        @(negedge clk);
        while (!err && n < 2000) begin @(negedge clk); n++; end
        check("wc0_err", {err, busy, mem_own, in_ready}, 4'b1000);
        check("wc0_reads", rd_exp, 0);
        $display("wc0: err=%0b reads=%0d", err, rd_exp);
        @(posedge clk); #1;
        do_reset();

        // size error: V=700 F=0 gives T=2102
        start_cycles = 0;
        send_word(0, 700, 0);
        send_word(1, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("size_err", {err, in_ready, busy, mem_own}, 4'b1000);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        @(negedge clk);
        check("size_err_hold", {err, in_ready}, 2'b10);
        check("size_err_nostart", start_cycles, 0);
        check("size_err_nowrite", obj_q.size(), 0);
        $display("size_err: err=%0b starts=%0d", err, start_cycles);
        @(posedge clk); #1;
        do_reset();

        // reset while word 10 of the unload is presented
        send_job(4, 2, 74, 74, 1, 20, 0);
        n = 0;
        while (!(out_hs == 10 && out_valid) && n < 5000) begin @(posedge clk); #1; n++; end
        check("mid_unload_reach", {out_hs[7:0], out_valid}, {8'd10, 1'b1});
        do_reset();
        send_job(1, 1, 5, 5, 1, 8, 0);
        finish_job(1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
